// File: rtl/crt_timing_pkg.sv
// crt_timing_pkg: 640x480 raster constants, decoder FSM states and coordinate width
package crt_timing_pkg;
  localparam int CW          = 10;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_START_DEF = 144;
  localparam int V_START_DEF = 35;
  localparam int XRES_DEF    = 640;
  localparam int YRES_DEF    = 480;
  localparam logic [CW-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_VERIFY, ST_LOCKED} dec_state_e;
endpackage

// File: rtl/crt_sync_sampler.sv
// crt_sync_sampler: 2-flop synchronizer plus assertion-edge detector for one sync line
module crt_sync_sampler #(
  parameter logic POL = 1'b0
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic tick_i,
  input  logic sync_i,
  output logic edge_o
);
  logic [1:0] sync_q;
  logic       prev_q;
  logic       asserted;
  assign asserted = sync_q[1] == POL;
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= {2{~POL}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sync_i};
      if (tick_i) prev_q <= asserted;
    end
  end
  assign edge_o = tick_i & asserted & ~prev_q;
endmodule

// File: rtl/crt_sync_decoder.sv
// crt_sync_decoder: measures an incoming hsync/vsync raster, locks onto it and regenerates coordinates.
// Define CRT_DECODER_STATS_EN to add frame_count_o / error_count_o statistics ports.
module crt_sync_decoder
  import crt_timing_pkg::*;
#(
  parameter int   H_START     = H_START_DEF,
  parameter int   V_START     = V_START_DEF,
  parameter int   XRES        = XRES_DEF,
  parameter int   YRES        = YRES_DEF,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          pixel_tick_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  output logic [CW-1:0] xposition_o,
  output logic [CW-1:0] yposition_o,
  output logic          active_o,
  output logic [CW-1:0] line_total_o,
  output logic [CW-1:0] frame_total_o,
  output logic          locked_o,
  output logic          frame_start_o,
  output logic          sync_error_o
`ifdef CRT_DECODER_STATS_EN
  ,
  output logic [15:0]   frame_count_o,
  output logic [7:0]    error_count_o
`endif
);
  logic          h_edge, v_edge, in_win;
  logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d, h_inc, v_inc;
  logic [CW-1:0] line_total_q, line_total_d, frame_total_q, frame_total_d;
  logic [CW-1:0] x_q, y_q, ref_line_q, ref_frame_q;
  logic [7:0]    match_q;
  logic          win_q, locked_q, frame_start_q, sync_error_q;
  dec_state_e    state_q;

  crt_sync_sampler #(.POL(SYNC_POL)) u_hs (
    .clock_i(clock_i), .reset_ni(reset_ni), .tick_i(pixel_tick_i), .sync_i(hsync_i), .edge_o(h_edge)
  );
  crt_sync_sampler #(.POL(SYNC_POL)) u_vs (
    .clock_i(clock_i), .reset_ni(reset_ni), .tick_i(pixel_tick_i), .sync_i(vsync_i), .edge_o(v_edge)
  );

  // Counters saturate; a simultaneous vsync edge clears vcount after the line is counted.
  assign h_inc         = (hcount_q == CNT_MAX) ? hcount_q : hcount_q + 1'b1;
  assign v_inc         = (vcount_q == CNT_MAX) ? vcount_q : vcount_q + 1'b1;
  assign hcount_d      = !pixel_tick_i ? hcount_q : h_edge ? '0 : h_inc;
  assign vcount_d      = !pixel_tick_i ? vcount_q : v_edge ? '0 : h_edge ? v_inc : vcount_q;
  assign line_total_d  = h_edge ? h_inc : line_total_q;
  assign frame_total_d = v_edge ? v_inc : frame_total_q;
  assign in_win = int'(hcount_d) >= H_START && int'(hcount_d) < H_START + XRES &&
                  int'(vcount_d) >= V_START && int'(vcount_d) < V_START + YRES;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      line_total_q  <= '0;
      frame_total_q <= '0;
      win_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_total_q  <= line_total_d;
      frame_total_q <= frame_total_d;
      win_q         <= in_win;
      x_q           <= in_win ? hcount_d - CW'(H_START) : '0;
      y_q           <= in_win ? vcount_d - CW'(V_START) : '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_SEARCH;
      match_q       <= '0;
      ref_line_q    <= '0;
      ref_frame_q   <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      frame_start_q <= v_edge && (state_q == ST_VERIFY || state_q == ST_LOCKED);
      sync_error_q  <= 1'b0;
      case (state_q)
        ST_SEARCH: if (v_edge) state_q <= ST_MEASURE;
        ST_MEASURE: if (v_edge) begin
          state_q     <= ST_VERIFY;
          ref_line_q  <= line_total_d;
          ref_frame_q <= frame_total_d;
          match_q     <= '0;
        end
        ST_VERIFY: if (v_edge) begin
          if (line_total_d == ref_line_q && frame_total_d == ref_frame_q) begin
            match_q <= match_q + 1'b1;
            // the reference frame itself counts as the first of the matching frames
            if (int'(match_q) + 2 >= LOCK_FRAMES) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end
          end else begin
            ref_line_q  <= line_total_d;
            ref_frame_q <= frame_total_d;
            match_q     <= '0;
          end
        end
        ST_LOCKED: if ((h_edge && line_total_d != ref_line_q) || hcount_d == CNT_MAX || vcount_d == CNT_MAX) begin
          state_q      <= ST_SEARCH;
          locked_q     <= 1'b0;
          sync_error_q <= 1'b1;
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign active_o      = locked_q & win_q;
  assign xposition_o   = locked_q ? x_q : '0;
  assign yposition_o   = locked_q ? y_q : '0;
  assign line_total_o  = line_total_q;
  assign frame_total_o = frame_total_q;
  assign locked_o      = locked_q;
  assign frame_start_o = frame_start_q;
  assign sync_error_o  = sync_error_q;

`ifdef CRT_DECODER_STATS_EN
  logic [15:0] frame_count_q;
  logic [7:0]  error_count_q;
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      if (frame_start_q) frame_count_q <= frame_count_q + 1'b1;
      if (sync_error_q && error_count_q != 8'hff) error_count_q <= error_count_q + 1'b1;
    end
  end
  assign frame_count_o = frame_count_q;
  assign error_count_o = error_count_q;
`endif
endmodule

// File: doc/crt_sync_decoder.md
# crt_sync_decoder

Receive-side counterpart of the CRT timing generator: samples incoming `hsync`/`vsync` on pixel ticks and measures line and frame totals. It locks onto a stable raster and regenerates `xposition`/`yposition` plus an active-video flag. It sits in front of display-capture and self-check logic, so the generator's output can be verified or consumed in-system.

## Interface
- `H_START`, 144, pixel ticks from hsync assertion to first active pixel (sync + back porch)
- `V_START`, 35, lines from vsync assertion to first active line
- `XRES`, 640, active pixels per line
- `YRES`, 480, active lines per frame
- `SYNC_POL`, 0, sync assertion level (0 = active-low pulses)
- `LOCK_FRAMES`, 2, consecutive matching frames required to lock
- `clock`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `pixel_tick`  in  1  one-cycle pixel enable (CRT clock rate)
- `hsync`, `vsync`  in  1 each  raster syncs from the generator
- `xposition`, `yposition`  out  10 each  active-area coordinates
- `active`  out  1  current pixel inside XRES×YRES window and locked
- `line_total`  out  10  last measured pixel ticks per line
- `frame_total`  out  10  last measured lines per frame
- `locked`  out  1  raster stable
- `frame_start`  out  1  one-cycle pulse on each accepted vsync assertion
- `sync_error`  out  1  one-cycle pulse on loss of lock

## Operation
- Syncs pass a 2-flop synchronizer. Assertion edge = previous sample deasserted and current sample asserted, at SYNC_POL level. Edges are evaluated only on `pixel_tick`.
- `hcount` counts pixel ticks and clears to 0 on the hsync edge. `vcount` counts hsync edges and clears to 0 on the vsync edge. Both are 10-bit and saturate at 1023; they do not wrap.
- On each hsync edge, `line_total` is loaded with `hcount+1`. On each vsync edge, `frame_total` is loaded with `vcount+1`.
- FSM states: SEARCH → MEASURE on the first vsync edge. MEASURE → VERIFY on the next vsync edge, which stores the reference totals. In VERIFY, each vsync edge with totals equal to the references increments the match counter; reaching LOCK_FRAMES moves to LOCKED. A mismatch in VERIFY stores the new references and clears the counter.
- In LOCKED, any line_total differing from the reference, or a saturated counter, pulses `sync_error` and moves to SEARCH.
- `xposition = hcount - H_START` and `yposition = vcount - V_START` (10-bit) while inside the window. Outside the window, or when not locked, both hold 0.
- `active` = locked AND H_START ≤ hcount < H_START+XRES AND V_START ≤ vcount < V_START+YRES.
- Simultaneous hsync and vsync edges: hsync is processed first, then vcount clears.

## Timing
- Reset values: every output is 0 and the FSM is in SEARCH. Reset assertion mid-frame takes effect immediately (asynchronous). Release is synchronous to the next `clock` edge.
- Sync input to internal edge detect: 2 clocks (synchronizer), then qualified by the next `pixel_tick`.
- Outputs are registered: one clock after the qualifying tick.
- `frame_start` is a one-clock pulse, emitted only when the FSM is in VERIFY or LOCKED.
- `locked` rises one clock after the LOCK_FRAMES-th matching vsync edge and falls together with the `sync_error` pulse.
- With `pixel_tick` held low, all state freezes.

## Configuration
- `CRT_DECODER_STATS_EN` defined:
  - adds `frame_count` (16-bit, increments on each `frame_start`, wraps)
  - adds `error_count` (8-bit, saturating at 255, increments on each `sync_error`)
  - both are output ports and both reset to 0
- Not defined: these ports and counters are absent.

## Structure
- Package `crt_timing_pkg`:
  - 640×480 timing constants (H total 800, V total 525, H_START 144, V_START 35)
  - FSM state enum
  - 10-bit coordinate width
- Sub-module `crt_sync_sampler`: synchronizer plus assertion-edge detector, one instance per sync line.

## Test plan
- Generator at 640×480 (100 MHz clock, tick every 4 clocks), reset low for 50 ns. Expected:
  - `locked` = 1 after the 3rd vsync edge
  - `line_total` = 800, `frame_total` = 525
- Locked raster, first active pixel: `active` rises at hcount 144 / vcount 35 with `xposition` = 0, `yposition` = 0. Last active pixel: (639, 479), then `active` falls.
- Stretch one line to 801 ticks while locked: `sync_error` pulses once, `locked` drops, and the decoder relocks after 3 further clean vsync edges.
- Hold hsync deasserted: hcount saturates at 1023, `sync_error` pulses once, and the FSM returns to SEARCH.
- Assert reset mid-frame in LOCKED: all outputs are 0 within the same clock. After release, the relock sequence repeats as in the first scenario.
- With `CRT_DECODER_STATS_EN` defined: `frame_count` = 5 after 5 locked frames, and `error_count` increments on the injected error.
